// File: rtl/multi_result_collector.sv
// rtl/multi_result_collector.sv - gathers one prediction per core, then streams them out in core order.
// Optional collect-phase timeout: define COLLECTOR_TIMEOUT_EN.
module multi_result_collector #(
   parameter int N              = 4,
   parameter int OUT_W          = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int IDX_W         = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N-1:0]       core_done,
   input  logic [N*OUT_W-1:0] core_value,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [OUT_W-1:0]   m_data,
   output logic [IDX_W-1:0]   m_idx,
   output logic               m_last,
   output logic               m_miss,
   output logic               busy,
   output logic               batch_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      FIN     = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   state_t           state;
   state_t           state_n;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_n;
   logic [N-1:0]     done_q;
   logic [N-1:0]     flags;
   logic [N-1:0]     cap_ev;
   logic [OUT_W-1:0] buffer [N];
   logic             timeout_hit;
   logic             slot_miss;
   logic             in_drain;

   // A capture is a rising edge of the done level; a level already high at
   // COLLECT entry was registered into done_q earlier and never qualifies.
   assign cap_ev = core_done & ~done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= '0;
      end else begin
         done_q <= core_done;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags <= '0;
      end else if (state == IDLE && start) begin
         flags <= '0;
      end else if (state == COLLECT) begin
         flags <= flags | cap_ev;
      end
   end

   // Buffer is left unreset: every slot is either written or flagged missing
   // before DRAIN, and missing slots are masked at the output.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (state == COLLECT && cap_ev[i] && !flags[i]) begin
            buffer[i] <= core_value[i*OUT_W +: OUT_W];
         end
      end
   end

`ifdef COLLECTOR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (state == COLLECT) begin
         cnt <= cnt + 1'b1;
      end else begin
         cnt <= '0;
      end
   end

   assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign slot_miss   = ~flags[idx];
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign timeout_hit    = 1'b0;
   assign slot_miss      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      case (state)
         IDLE: begin
            idx_n = '0;
            if (start) begin
               state_n = COLLECT;
            end
         end
         COLLECT: begin
            if ((&flags) || timeout_hit) begin
               state_n = DRAIN;
               idx_n   = '0;
            end
         end
         DRAIN: begin
            if (m_ready) begin
               if (idx == LAST_IDX) begin
                  state_n = FIN;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         FIN: begin
            state_n = IDLE;
            idx_n   = '0;
         end
         default: begin
            state_n = IDLE;
            idx_n   = '0;
         end
      endcase
   end

   // Outputs decode only state, idx, flags and buffer, so they hold during a stall.
   assign in_drain   = (state == DRAIN);
   assign m_valid    = in_drain;
   assign m_idx      = in_drain ? idx : '0;
   assign m_last     = in_drain && (idx == LAST_IDX);
   assign m_miss     = in_drain && slot_miss;
   assign m_data     = (in_drain && !slot_miss) ? buffer[idx] : '0;
   assign busy       = (state != IDLE);
   assign batch_done = (state == FIN);

endmodule
